multi_cycle_ctrl: RTL

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit.
// Decodes the held instruction into datapath selects and sequences the
// FETCH / DECODE / EXEC / MEM / WB / MDWAIT states. It also counts the
// busy cycles of the external multiply/divide unit.
module multi_cycle_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCwrite,
    output logic       IRwrite,
    output logic       Regwrite,
    output logic       Memwrite,
    output logic       Memread,
    output logic       MDstart,
    output logic [1:0] RegDst,
    output logic       EXTop,
    output logic [1:0] ALUsrc,
    output logic [2:0] ALUctrl,
    output logic [2:0] MemtoReg,
    output logic [1:0] NPCop,
    output logic [1:0] MDop,
    output logic       MDbusy,
    output logic [2:0] state
);

    // Opcode field encodings
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Function field encodings for R-type
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_DIV  = 6'b011010;
    localparam logic [5:0] FN_MFHI = 6'b010000;
    localparam logic [5:0] FN_MFLO = 6'b010010;

    // Multiply/divide counter constants
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        I_NOP  = 4'd0,
        I_ADD  = 4'd1,
        I_SUB  = 4'd2,
        I_ORI  = 4'd3,
        I_LW   = 4'd4,
        I_SW   = 4'd5,
        I_BEQ  = 4'd6,
        I_LUI  = 4'd7,
        I_J    = 4'd8,
        I_JAL  = 4'd9,
        I_JR   = 4'd10,
        I_MULT = 4'd11,
        I_DIV  = 4'd12,
        I_MFHI = 4'd13,
        I_MFLO = 4'd14
    } instr_t;

    state_t            state_r;
    state_t            next_state_s;
    instr_t            instr_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        npc_dec_s;

    assign state = state_r;

    // Classify the held instruction; anything unrecognised becomes a nop
    always_comb begin
        instr_s = I_NOP;
        case (OP)
            OP_RTYPE: begin
                case (Func)
                    FN_ADD:  instr_s = I_ADD;
                    FN_SUB:  instr_s = I_SUB;
                    FN_JR:   instr_s = I_JR;
                    FN_MULT: instr_s = I_MULT;
                    FN_DIV:  instr_s = I_DIV;
                    FN_MFHI: instr_s = I_MFHI;
                    FN_MFLO: instr_s = I_MFLO;
                    default: instr_s = I_NOP;
                endcase
            end
            OP_ORI:  instr_s = I_ORI;
            OP_LW:   instr_s = I_LW;
            OP_SW:   instr_s = I_SW;
            OP_BEQ:  instr_s = I_BEQ;
            OP_LUI:  instr_s = I_LUI;
            OP_J:    instr_s = I_J;
            OP_JAL:  instr_s = I_JAL;
            default: instr_s = I_NOP;
        endcase
    end

    // Datapath selects, driven from the instruction in every state
    always_comb begin
        RegDst    = 2'b00;
        EXTop     = 1'b0;
        ALUsrc    = 2'b00;
        ALUctrl   = 3'b000;
        MemtoReg  = 3'b000;
        npc_dec_s = 2'b00;
        MDop      = 2'b00;
        case (instr_s)
            I_ADD: begin
                RegDst = 2'b01;
            end
            I_SUB: begin
                RegDst  = 2'b01;
                ALUctrl = 3'b001;
            end
            I_ORI: begin
                ALUsrc  = 2'b01;
                ALUctrl = 3'b010;
            end
            I_LW: begin
                EXTop    = 1'b1;
                ALUsrc   = 2'b01;
                MemtoReg = 3'b001;
            end
            I_SW: begin
                EXTop  = 1'b1;
                ALUsrc = 2'b01;
            end
            I_BEQ: begin
                EXTop     = 1'b1;
                ALUctrl   = 3'b001;
                npc_dec_s = 2'b10;
            end
            I_LUI: begin
                ALUsrc   = 2'b01;
                MemtoReg = 3'b011;
            end
            I_J: begin
                npc_dec_s = 2'b01;
            end
            I_JAL: begin
                RegDst    = 2'b10;
                MemtoReg  = 3'b010;
                npc_dec_s = 2'b01;
            end
            I_JR: begin
                npc_dec_s = 2'b11;
            end
            I_MULT: begin
                MDop = 2'b01;
            end
            I_DIV: begin
                MDop = 2'b10;
            end
            I_MFHI: begin
                RegDst   = 2'b01;
                MemtoReg = 3'b100;
            end
            I_MFLO: begin
                RegDst   = 2'b01;
                MemtoReg = 3'b101;
            end
            default: begin
                RegDst = 2'b00;
            end
        endcase
    end

    // The fetch PC update is always sequential, whatever the old IR says
    always_comb begin
        if ((state_r == S_FETCH) && mem_ready) begin
            NPCop = 2'b00;
        end else begin
            NPCop = npc_dec_s;
        end
    end

    // Next-state and state-gated strobes
    always_comb begin
        next_state_s = state_r;
        PCwrite      = 1'b0;
        IRwrite      = 1'b0;
        Regwrite     = 1'b0;
        Memwrite     = 1'b0;
        Memread      = 1'b0;
        MDstart      = 1'b0;
        MDbusy       = 1'b0;
        case (state_r)
            S_FETCH: begin
                Memread = 1'b1;
                // reset gates the fetch strobes so a held reset writes nothing
                if (mem_ready && reset) begin
                    IRwrite      = 1'b1;
                    PCwrite      = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (instr_s)
                    I_J, I_JR: begin
                        PCwrite      = 1'b1;
                        next_state_s = S_FETCH;
                    end
                    I_JAL: begin
                        PCwrite      = 1'b1;
                        next_state_s = S_WB;
                    end
                    I_NOP: begin
                        next_state_s = S_FETCH;
                    end
                    default: begin
                        next_state_s = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                case (instr_s)
                    I_BEQ: begin
                        PCwrite      = Zero;
                        next_state_s = S_FETCH;
                    end
                    I_LW, I_SW: begin
                        next_state_s = S_MEM;
                    end
                    I_MULT, I_DIV: begin
                        MDstart      = 1'b1;
                        next_state_s = S_MDWAIT;
                    end
                    default: begin
                        next_state_s = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                if (instr_s == I_SW) begin
                    Memwrite     = 1'b1;
                    next_state_s = mem_ready ? S_FETCH : S_MEM;
                end else if (instr_s == I_LW) begin
                    Memread      = 1'b1;
                    next_state_s = mem_ready ? S_WB : S_MEM;
                end else begin
                    // IR changed under us; drop the access rather than hang
                    next_state_s = S_FETCH;
                end
            end
            S_WB: begin
                Regwrite     = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MDWAIT: begin
                MDbusy = 1'b1;
                // leaving on 1 gives exactly N cycles; 0 is a safe escape
                if (cnt_r <= CNT_ONE) begin
                    next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MDWAIT;
                end
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // State register; reset forces FETCH without waiting for a clock
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Multiply/divide busy counter: load in EXEC, saturating count-down in MDWAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= CNT_ZERO;
        end else if ((state_r == S_EXEC) && (instr_s == I_MULT)) begin
            cnt_r <= MUL_LOAD;
        end else if ((state_r == S_EXEC) && (instr_s == I_DIV)) begin
            cnt_r <= DIV_LOAD;
        end else if ((state_r == S_MDWAIT) && (cnt_r != CNT_ZERO)) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule
